// File: rtl/cdc_async_fifo.sv
// Dual-clock FIFO: Gray-coded pointers cross domains through SYNC_STAGES-deep
// synchronizer chains; flags and levels are registered and pessimistic.
`timescale 1ns/1ps
module cdc_async_fifo #(
    parameter int DW          = 32,
    parameter int AW          = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic          WCLK,
    input  logic          RCLK,
    input  logic          CLR,
    input  logic          WINC,
    input  logic [DW-1:0] WDATA,
    output logic          WFULL,
    output logic [AW:0]   WLEVEL,
    output logic          WOVF,
    input  logic          RINC,
    output logic [DW-1:0] RDATA,
    output logic          REMPTY,
    output logic [AW:0]   RLEVEL,
    output logic          RUDF
);
    localparam int DEPTH = 1 << AW;

    logic [DW-1:0] mem [DEPTH];

    logic [AW:0] wbin, wgray, wbin_next, wgray_next;
    logic [AW:0] rbin, rgray, rbin_next, rgray_next;
    logic [AW:0] rq_sync [SYNC_STAGES];
    logic [AW:0] wq_sync [SYNC_STAGES];
    logic [AW:0] rq_gray, wq_gray;
    logic        wpush, rpop;

    function automatic logic [AW:0] gray2bin(input logic [AW:0] g);
        logic [AW:0] b;
        b[AW] = g[AW];
        for (int i = AW - 1; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    // ---------------- write domain ----------------
    assign wpush      = WINC & ~WFULL;
    assign wbin_next  = wbin + {{AW{1'b0}}, wpush};
    assign wgray_next = wbin_next ^ (wbin_next >> 1);
    assign rq_gray    = rq_sync[SYNC_STAGES-1];

    always_ff @(posedge WCLK or negedge CLR) begin
        if (!CLR) begin
            wbin   <= '0;
            wgray  <= '0;
            WFULL  <= 1'b0;
            WLEVEL <= '0;
            WOVF   <= 1'b0;
            for (int i = 0; i < SYNC_STAGES; i++) begin
                rq_sync[i] <= '0;
            end
        end else begin
            wbin   <= wbin_next;
            wgray  <= wgray_next;
            // full when the writer is exactly one lap ahead of the synced reader
            WFULL  <= (wgray_next == {~rq_gray[AW:AW-1], rq_gray[AW-2:0]});
            WLEVEL <= wbin_next - gray2bin(rq_gray);
            WOVF   <= WOVF | (WINC & WFULL);
            rq_sync[0] <= rgray;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                rq_sync[i] <= rq_sync[i-1];
            end
        end
    end

    always_ff @(posedge WCLK) begin
        if (wpush) begin
            mem[wbin[AW-1:0]] <= WDATA;
        end
    end

    // ---------------- read domain ----------------
    assign rpop       = RINC & ~REMPTY;
    assign rbin_next  = rbin + {{AW{1'b0}}, rpop};
    assign rgray_next = rbin_next ^ (rbin_next >> 1);
    assign wq_gray    = wq_sync[SYNC_STAGES-1];
    assign RDATA      = mem[rbin[AW-1:0]];

    always_ff @(posedge RCLK or negedge CLR) begin
        if (!CLR) begin
            rbin   <= '0;
            rgray  <= '0;
            REMPTY <= 1'b1;
            RLEVEL <= '0;
            RUDF   <= 1'b0;
            for (int i = 0; i < SYNC_STAGES; i++) begin
                wq_sync[i] <= '0;
            end
        end else begin
            rbin   <= rbin_next;
            rgray  <= rgray_next;
            REMPTY <= (rgray_next == wq_gray);
            RLEVEL <= gray2bin(wq_gray) - rbin_next;
            RUDF   <= RUDF | (RINC & REMPTY);
            wq_sync[0] <= wgray;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                wq_sync[i] <= wq_sync[i-1];
            end
        end
    end

endmodule

// File: tb/tb_cdc_async_fifo.sv
// Scoreboard bench for cdc_async_fifo: directed fill/drain/reset/latency cases
// followed by randomized multi-ratio streaming against a queue model.
`timescale 1ns/1ps
module tb_cdc_async_fifo;
    localparam int DW    = 32;
    localparam int AW    = 4;
    localparam int SS    = 2;
    localparam int DEPTH = 1 << AW;

    logic          WCLK = 1'b0;
    logic          RCLK = 1'b0;
    logic          CLR  = 1'b1;
    logic          WINC = 1'b0;
    logic          RINC = 1'b0;
    logic [DW-1:0] WDATA = '0;
    logic          WFULL, WOVF, REMPTY, RUDF;
    logic [AW:0]   WLEVEL, RLEVEL;
    logic [DW-1:0] RDATA;

    realtime wh = 5.0;
    realtime rh = 13.5;

    int            checks = 0;
    int            errors = 0;
    int            total_read = 0;
    bit            done = 1'b0;
    logic [DW-1:0] q[$];

    cdc_async_fifo #(.DW(DW), .AW(AW), .SYNC_STAGES(SS)) dut (
        .WCLK(WCLK), .RCLK(RCLK), .CLR(CLR),
        .WINC(WINC), .WDATA(WDATA), .WFULL(WFULL), .WLEVEL(WLEVEL), .WOVF(WOVF),
        .RINC(RINC), .RDATA(RDATA), .REMPTY(REMPTY), .RLEVEL(RLEVEL), .RUDF(RUDF)
    );

    always #(wh) WCLK = ~WCLK;
    always #(rh) RCLK = ~RCLK;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    task automatic fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s: got timeout/unexpected state required normal progress", name);
    endtask

    task automatic write_word(input logic [DW-1:0] d);
        int n = 0;
        @(posedge WCLK); #1;
        while (WFULL && n < 200) begin
            @(posedge WCLK); #1;
            n++;
        end
        if (WFULL) begin
            fail("write_timeout");
            return;
        end
        WDATA = d;
        WINC  = 1'b1;
        q.push_back(d);
        @(posedge WCLK); #1;
        WINC = 1'b0;
    endtask

    task automatic pop_check(input string name);
        int            n = 0;
        logic [DW-1:0] e;
        @(posedge RCLK); #1;
        while (REMPTY && n < 64) begin
            @(posedge RCLK); #1;
            n++;
        end
        if (REMPTY) begin
            fail({name, "_timeout"});
            return;
        end
        if (q.size() == 0) begin
            fail({name, "_unexpected_data"});
            return;
        end
        e = q.pop_front();
        chk(name, 64'(RDATA), 64'(e));
        RINC = 1'b1;
        @(posedge RCLK); #1;
        RINC = 1'b0;
    endtask

    task automatic writer_rand(input int n);
        int          sent = 0;
        int          iter = 0;
        int unsigned duty = 100;
        logic [DW-1:0] d;
        while (sent < n && iter < 400000) begin
            @(posedge WCLK); #1;
            WINC = 1'b0;
            if (iter % 128 == 0) duty = $urandom_range(10, 100);
            iter++;
            if (q.size() >= DEPTH) begin
                checks++;
                if (!WFULL) begin
                    errors++;
                    $display("FAIL full_flag: got WFULL=0 required 1 with %0d outstanding", q.size());
                end
            end
            if (!WFULL && $urandom_range(1, 100) <= duty) begin
                d     = $urandom;
                WDATA = d;
                WINC  = 1'b1;
                q.push_back(d);
                sent++;
            end
        end
        @(posedge WCLK); #1;
        WINC = 1'b0;
        if (sent < n) fail("writer_budget");
    endtask

    task automatic reader_rand(input int n);
        int          got = 0;
        int          iter = 0;
        int unsigned duty = 100;
        logic [DW-1:0] e;
        while (got < n && iter < 400000) begin
            @(posedge RCLK); #1;
            RINC = 1'b0;
            if (iter % 128 == 0) duty = $urandom_range(10, 100);
            iter++;
            if (q.size() == 0) begin
                checks++;
                if (!REMPTY) begin
                    errors++;
                    $display("FAIL empty_flag: got REMPTY=0 required 1 with nothing outstanding");
                end
            end else if (!REMPTY && $urandom_range(1, 100) <= duty) begin
                e = q.pop_front();
                checks++;
                if (RDATA !== e) begin
                    errors++;
                    $display("FAIL stream_data: got %0h required %0h (word %0d)", RDATA, e, total_read);
                end
                RINC = 1'b1;
                got++;
                total_read++;
            end
        end
        @(posedge RCLK); #1;
        RINC = 1'b0;
        if (got < n) fail("reader_budget");
    endtask

    initial begin
        fork
            begin : main_seq
                int  k;
                int  lat;
                bit  seen;
                bit  acc;
                // ---- power-on reset ----
                #1 CLR = 1'b0;
                #20;
                chk("rst_wfull",  64'(WFULL),  64'(0));
                chk("rst_rempty", 64'(REMPTY), 64'(1));
                chk("rst_wlevel", 64'(WLEVEL), 64'(0));
                chk("rst_rlevel", 64'(RLEVEL), 64'(0));
                chk("rst_wovf",   64'(WOVF),   64'(0));
                chk("rst_rudf",   64'(RUDF),   64'(0));
                @(negedge WCLK);
                CLR = 1'b1;
                repeat (3) @(posedge RCLK);

                // ---- fill to full and overflow ----
                k = 0;
                @(posedge WCLK); #1;
                for (int i = 0; i <= DEPTH; i++) begin
                    chk("full_before_write", 64'(WFULL), 64'(k == DEPTH));
                    acc   = (k < DEPTH);
                    WDATA = DW'(i);
                    WINC  = 1'b1;
                    if (acc) q.push_back(DW'(i));
                    @(posedge WCLK); #1;
                    WINC = 1'b0;
                    if (acc) begin
                        k++;
                        chk("fill_wlevel", 64'(WLEVEL), 64'(k));
                        chk("fill_wfull",  64'(WFULL),  64'(k == DEPTH));
                    end else begin
                        chk("ovf_sticky", 64'(WOVF), 64'(1));
                    end
                end

                // ---- drain and underflow ----
                for (int i = 0; i < DEPTH; i++) pop_check("drain_data");
                chk("empty_on_last_pop", 64'(REMPTY), 64'(1));
                chk("drain_rlevel",      64'(RLEVEL), 64'(0));
                @(posedge RCLK); #1;
                RINC = 1'b1;
                @(posedge RCLK); #1;
                RINC = 1'b0;
                chk("udf_sticky",  64'(RUDF),   64'(1));
                chk("udf_rempty",  64'(REMPTY), 64'(1));
                write_word(32'h77);
                pop_check("after_udf_data");

                // ---- write-to-read latency ----
                repeat (4) @(posedge RCLK);
                @(posedge WCLK); #1;
                WDATA = 32'h1234_5678;
                WINC  = 1'b1;
                q.push_back(32'h1234_5678);
                @(posedge WCLK);
                lat  = 0;
                seen = 1'b0;
                fork
                    begin #1; WINC = 1'b0; end
                    begin
                        while (lat < 10 && !seen) begin
                            @(posedge RCLK);
                            lat++;
                            #1;
                            if (!REMPTY) seen = 1'b1;
                        end
                    end
                join
                checks++;
                if (!seen || lat < SS + 1 || lat > SS + 2) begin
                    errors++;
                    $display("FAIL empty_latency: got %0d edges required %0d..%0d", lat, SS + 1, SS + 2);
                end
                pop_check("latency_data");

                // ---- reset mid-stream ----
                for (int i = 0; i < 5; i++) write_word(DW'(100 + i));
                pop_check("pre_reset_data");
                pop_check("pre_reset_data");
                @(negedge WCLK);
                CLR = 1'b0;
                #2;
                chk("mid_rst_wfull",  64'(WFULL),  64'(0));
                chk("mid_rst_rempty", 64'(REMPTY), 64'(1));
                chk("mid_rst_wlevel", 64'(WLEVEL), 64'(0));
                chk("mid_rst_rlevel", 64'(RLEVEL), 64'(0));
                chk("mid_rst_wovf",   64'(WOVF),   64'(0));
                chk("mid_rst_rudf",   64'(RUDF),   64'(0));
                q.delete();
                repeat (2) @(posedge RCLK);
                @(negedge WCLK);
                CLR = 1'b1;
                write_word(32'hA5);
                pop_check("post_reset_first");

                // ---- randomized stress over three clock ratios ----
                for (int p = 0; p < 3; p++) begin
                    int n;
                    n = (p == 0) ? 3334 : 3333;
                    case (p)
                        0:       begin wh = 15.0; rh = 5.0;  end
                        1:       begin wh = 5.0;  rh = 5.0;  end
                        default: begin wh = 5.0;  rh = 15.0; end
                    endcase
                    repeat (4) @(posedge WCLK);
                    fork
                        writer_rand(n);
                        reader_rand(n);
                    join
                end
                chk("stress_words",  64'(total_read), 64'(10000));
                chk("stress_leftover", 64'(q.size()), 64'(0));
                chk("stress_no_wovf", 64'(WOVF), 64'(0));
                chk("stress_no_rudf", 64'(RUDF), 64'(0));
                done = 1'b1;
            end
            begin : gray_w_mon
                logic [AW:0] pw;
                logic [AW:0] g;
                pw = '0;
                while (!done) begin
                    @(negedge WCLK);
                    if (!CLR) begin
                        pw = '0;
                    end else begin
                        g = dut.wgray;
                        if (g != pw) begin
                            checks++;
                            if ($countones(g ^ pw) != 1) begin
                                errors++;
                                $display("FAIL gray_w_step: got %0h after %0h required one-bit change", g, pw);
                            end
                        end
                        pw = g;
                    end
                end
            end
            begin : gray_r_mon
                logic [AW:0] pr;
                logic [AW:0] g;
                pr = '0;
                while (!done) begin
                    @(negedge RCLK);
                    if (!CLR) begin
                        pr = '0;
                    end else begin
                        g = dut.rgray;
                        if (g != pr) begin
                            checks++;
                            if ($countones(g ^ pr) != 1) begin
                                errors++;
                                $display("FAIL gray_r_step: got %0h after %0h required one-bit change", g, pr);
                            end
                        end
                        pr = g;
                    end
                end
            end
        join
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cdc_async_fifo.md
# cdc_async_fifo

Dual-clock FIFO that moves a DW-bit data stream from the WCLK domain to the RCLK domain. It is the next stage after our metastability-modelling flop: its Gray-coded pointer crossings are built from SYNC_STAGES-deep synchronizer chains, so CDC bugs show up in simulation. It sits between any producer/consumer pair on unrelated clocks, for example AXI/APB bridge data paths.

## Interface
- DW, 32, data width in bits
- AW, 4, address width; depth = 2^AW entries; legal range 2..8
- SYNC_STAGES, 2, flops per pointer synchronizer chain; legal range 2..4
- WCLK  input  1  write-domain clock
- RCLK  input  1  read-domain clock
- CLR  input  1  reset, asynchronous, active-low. Clears both domains. Deassertion is synchronous to each clock, guaranteed by the system reset generator.
- WINC  input  1  write request, sampled at posedge WCLK
- WDATA  input  DW  write data, sampled with WINC
- WFULL  output  1  FIFO full (WCLK domain, registered)
- WLEVEL  output  AW+1  occupancy as seen by the writer (registered, pessimistic)
- WOVF  output  1  sticky overflow error (WCLK domain)
- RINC  input  1  read/pop request, sampled at posedge RCLK
- RDATA  output  DW  head entry, first-word-fall-through
- REMPTY  output  1  FIFO empty (RCLK domain, registered)
- RLEVEL  output  AW+1  occupancy as seen by the reader (registered, pessimistic)
- RUDF  output  1  sticky underflow error (RCLK domain)

## Operation
- Storage: 2^AW x DW register array. Written in WCLK domain, read combinationally at raddr. Storage is not reset.
- Pointers: wbin and rbin are AW+1 bits binary. wgray and rgray are the registered Gray form, gray = bin ^ (bin >> 1). Only the Gray registers cross domains.
- Synchronizers: rgray goes through SYNC_STAGES WCLK flops to give rq_gray. wgray goes through SYNC_STAGES RCLK flops to give wq_gray. All flops are cleared by CLR.
- Write: if WINC=1 and WFULL=0 at posedge WCLK, then mem[wbin[AW-1:0]] <= WDATA and wbin increments.
- Read: if RINC=1 and REMPTY=0 at posedge RCLK, rbin increments.
- Full: WFULL <= (wgray_next == {~rq_gray[AW:AW-1], rq_gray[AW-2:0]}).
- Empty: REMPTY <= (rgray_next == wq_gray).
- Levels: WLEVEL <= wbin_next − gray2bin(rq_gray). RLEVEL <= gray2bin(wq_gray) − rbin_next. Both are modulo 2^(AW+1) and never exceed 2^AW.
- Overflow: WINC=1 while WFULL=1 is ignored. Memory and pointer are unchanged, and WOVF <= 1.
- Underflow: RINC=1 while REMPTY=1 is ignored. The pointer is unchanged, and RUDF <= 1.
- WOVF and RUDF are cleared only by CLR.
- Flags are pessimistic:
  - WFULL may stay high after reads until the updated rptr is synchronized.
  - REMPTY may stay high after writes until the updated wptr is synchronized.
  - The FIFO never overflows or underflows internally.

## Timing
- Reset values (immediate on CLR low): WFULL=0, REMPTY=1, WLEVEL=0, RLEVEL=0, WOVF=0, RUDF=0, all pointers and sync flops 0. RDATA is undefined while REMPTY=1.
- Write to WFULL: WFULL rises on the same WCLK edge that accepts the 2^AW-th outstanding entry.
- Read to REMPTY: REMPTY rises on the same RCLK edge that pops the last entry.
- Write to read visibility: REMPTY falls SYNC_STAGES+1 RCLK edges after the wgray update, plus at most 1 edge for sampling phase.
- Read to write release: WFULL falls SYNC_STAGES+1 WCLK edges after the rgray update, plus at most 1 edge.
- RDATA: valid in the same cycle REMPTY=0. It advances to the next entry after each accepted pop edge, with no extra latency.
- Simultaneous events: a write accepted while full is impossible by construction. When one domain pushes while the other pops, each domain updates only its own pointer, so there is no conflict.
- Wrap-around: the pointer MSB toggles every 2^AW operations. Full and empty compare with the MSB, so the 0 ↔ 2^AW wrap is exact.
- Reset mid-operation: contents are discarded. The FIFO behaves exactly as after power-on reset once CLR deasserts.

## Test plan
- Reset: pulse CLR low mid-stream (after 5 writes, 2 reads) -> WFULL=0, REMPTY=1, levels 0, error flags 0. The next write 0xA5 is the first word read back.
- Fill/overflow (AW=4, WCLK 100 MHz, RCLK 37 MHz, no reads): write 0..16 -> WFULL=1 on the 16th accept and WLEVEL=16. The 17th write sets WOVF=1. Draining returns 0..15 in order.
- Drain/underflow: after the drain, REMPTY=1 on the last pop. An extra RINC sets RUDF=1, and a later write of 0x77 reads back 0x77.
- Latency: a single write into an empty FIFO -> REMPTY falls 3–4 RCLK edges after the write edge (SYNC_STAGES=2).
- Wrap/stress: 10,000 random words at random WINC/RINC duty (10–100%) over clock ratios 1:3, 1:1 and 3:1 -> scoreboard matches exactly, no WOVF/RUDF, pointers wrap at least 100 times.
- Gray check: assert that wgray and rgray change by exactly 1 bit per update throughout all runs.
